// File: rtl/uart_pkg.sv
// Shared types for the uart_tx arbiter slice: FSM state encoding and byte width.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } uart_arb_state_t;

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational winner select over the request valids. Round-robin from ptr by default;
// with UART_TX_ARB_FIXED_PRIO_EN defined the lowest-index valid channel wins and ptr is ignored.
module uart_rr_arb #(
  parameter int NREQ = 4,
  parameter int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [GW-1:0]   ptr,
  output logic [GW-1:0]   winner,
  output logic            any
);

  assign any = |req_valid;

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  always_comb begin
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) winner = GW'(i);
    end
  end
`else
  // Scan upward from ptr, wrapping at NREQ-1; the first valid channel wins.
  always_comb begin
    int   idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[GW'(idx)]) begin
        winner = GW'(idx);
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NREQ byte requesters: arbitrates, drives fill/tx_data, tracks empty.
// Build option: UART_TX_ARB_FIXED_PRIO_EN selects fixed lowest-index priority (no RR pointer).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 1024,
  localparam int GW      = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        enable,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]             req_ready,
  output logic                        fill,
  output logic [UART_BYTE_W-1:0]      tx_data,
  input  logic                        empty,
  output logic [GW-1:0]               grant,
  output logic                        busy,
  output logic                        err,
  output uart_arb_state_t             dbg_state
);

  localparam int             CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  uart_arb_state_t         state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [UART_BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic                    fill_q, fill_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic [NREQ-1:0]         req_ready_q, req_ready_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [GW-1:0]           ptr_q;
  logic [GW-1:0]           winner;
  logic                    any;
  logic                    take;
  logic [UART_BYTE_W-1:0]  win_byte;

  uart_rr_arb #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .winner    (winner),
    .any       (any)
  );

  assign take = (state_q == IDLE) && enable && any;

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == GW'(i)) win_byte = req_data[UART_BYTE_W*i +: UART_BYTE_W];
    end
  end

`ifdef UART_TX_ARB_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  logic [GW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (take) ptr_d = (winner == GW'(NREQ - 1)) ? '0 : winner + GW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    tx_data_d   = tx_data_q;
    fill_d      = fill_q;
    busy_d      = busy_q;
    err_d       = 1'b0;
    req_ready_d = '0;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          grant_d   = winner;
          tx_data_d = win_byte;
          fill_d    = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        // A latched byte is acknowledged even if enable drops in the same cycle,
        // otherwise the requester would resend a byte the transmitter already took.
        if (!empty) begin
          fill_d               = 1'b0;
          req_ready_d[grant_q] = 1'b1;
          state_d              = DRAIN;
        end else if (!enable) begin
          fill_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          fill_d  = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (empty) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        fill_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      tx_data_q   <= '0;
      fill_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      tx_data_q   <= tx_data_d;
      fill_q      <= fill_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign fill      = fill_q;
  assign tx_data   = tx_data_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
